// File: rtl/ring_counter_checker.sv
// Receive-side health monitor for an N-bit one-hot ring counter: decodes, checks rotation, tracks lock.
// Optional macro RING_CAPTURE_EN adds a bad_word output holding the last offending sample.
module ring_counter_checker #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         ring_in,
  input  logic                 sample_en,
  input  logic                 clr_err,
  output logic [$clog2(N)-1:0] index,
  output logic                 onehot_ok,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_W-1:0]     err_count
`ifdef RING_CAPTURE_EN
  ,
  output logic [N-1:0]         bad_word
`endif
);

  localparam int          IDX_W      = $clog2(N);
  localparam logic [3:0]  LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_MAX_C = 4'(MISS_MAX);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [3:0]         run_cnt_q, run_cnt_d;
  logic [3:0]         miss_cnt_q, miss_cnt_d;
  logic [N-1:0]       prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               onehot_ok_q, onehot_ok_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic               is_onehot;
  logic               match;
  logic [IDX_W-1:0]   hot_idx;
  logic [N-1:0]       prev_next;

  function automatic logic [N-1:0] rot(input logic [N-1:0] w);
    return {w[N-2:0], w[N-1]};
  endfunction

  assign prev_next = rot(prev_q);
  assign is_onehot = ($countones(ring_in) == 1);
  assign match     = have_prev_q && (ring_in == prev_next);

  // Only meaningful when ring_in is one-hot; otherwise the result is ignored.
  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i]) hot_idx = IDX_W'(i);
    end
  end

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    index_d     = index_q;
    onehot_ok_d = onehot_ok_q;
    err_d       = 1'b0;

    if (sample_en) begin
      onehot_ok_d = is_onehot;
      if (is_onehot) index_d = hot_idx;

      case (state_q)
        UNLOCKED: begin
          if (is_onehot) begin
            run_cnt_d   = match ? run_cnt_q + 4'd1 : 4'd1;
            prev_d      = ring_in;
            have_prev_d = 1'b1;
            if (run_cnt_d == LOCK_CNT_C) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            run_cnt_d   = '0;
            have_prev_d = 1'b0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
            prev_d     = ring_in;
          end else begin
            // Freewheel the expectation so one glitched sample costs only one error.
            err_d      = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            prev_d     = prev_next;
            if (miss_cnt_d == MISS_MAX_C) begin
              state_d     = UNLOCKED;
              run_cnt_d   = '0;
              have_prev_d = 1'b0;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    // Clear first, then count this cycle's event, so clear+error leaves 1.
    err_count_d = clr_err ? '0 : err_count_q;
    if (err_d && (err_count_d != '1)) err_count_d = err_count_d + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      run_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      index_q     <= '0;
      onehot_ok_q <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      index_q     <= index_d;
      onehot_ok_q <= onehot_ok_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign index     = index_q;
  assign onehot_ok = onehot_ok_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;

`ifdef RING_CAPTURE_EN
  logic [N-1:0] bad_word_q, bad_word_d;

  // Survives clr_err on purpose: only reset discards the captured word.
  always_comb begin
    bad_word_d = bad_word_q;
    if (err_d) bad_word_d = ring_in;
  end

  always_ff @(posedge clk) begin
    if (rst) bad_word_q <= '0;
    else     bad_word_q <= bad_word_d;
  end

  assign bad_word = bad_word_q;
`else
  // No capture register in this build.
`endif

endmodule

// File: tb/tb_ring_counter_checker.sv
// Scoreboard bench for ring_counter_checker; define RING_CAPTURE_EN to also check bad_word.
module tb_ring_counter_checker;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     ring_in;
  logic             sample_en;
  logic             clr_err;
  logic [1:0]       index;
  logic             onehot_ok;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
`ifdef RING_CAPTURE_EN
  logic [N-1:0]     bad_word;
`endif

  ring_counter_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .sample_en (sample_en),
    .clr_err   (clr_err),
    .index     (index),
    .onehot_ok (onehot_ok),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
`ifdef RING_CAPTURE_EN
    ,
    .bad_word  (bad_word)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       index;
    logic             onehot_ok;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [N-1:0]     bad_word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  bit         m_locked;
  int         m_run, m_miss;
  logic [3:0] m_prev;
  bit         m_have;
  logic [1:0] m_index;
  bit         m_ok, m_err;
  int         m_cnt;
  logic [3:0] m_bad;

  function automatic logic [3:0] next_w(input logic [3:0] w);
    return {w[2:0], w[3]};
  endfunction

  function automatic logic [1:0] pos_of(input logic [3:0] w);
    case (w)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: scoreboard empty observed 0 expected 1 entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".index"},     32'(index),     32'(e.index));
    check({tag, ".onehot_ok"}, 32'(onehot_ok), 32'(e.onehot_ok));
    check({tag, ".locked"},    32'(locked),    32'(e.locked));
    check({tag, ".err"},       32'(err),       32'(e.err));
    check({tag, ".err_count"}, 32'(err_count), 32'(e.err_count));
`ifdef RING_CAPTURE_EN
    check({tag, ".bad_word"},  32'(bad_word),  32'(e.bad_word));
`endif
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.index     = m_index;
    e.onehot_ok = m_ok;
    e.locked    = m_locked;
    e.err       = m_err;
    e.err_count = CNT_W'(m_cnt);
    e.bad_word  = m_bad;
    return e;
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1; sample_en = 1'b0; clr_err = 1'b0;
    m_locked = 0; m_run = 0; m_miss = 0; m_prev = '0; m_have = 0;
    m_index = '0; m_ok = 0; m_err = 0; m_cnt = 0; m_bad = '0;
    exp_q.push_back(snapshot());
    @(posedge clk); #1;
    compare(tag);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [3:0] w, input logic en, input logic clr, input string tag);
    bit oh, mt;
    ring_in = w; sample_en = en; clr_err = clr;
    m_err = 0;
    if (en) begin
      oh = ($countones(w) == 1);
      mt = m_have && (w == next_w(m_prev));
      m_ok = oh;
      if (oh) m_index = pos_of(w);
      if (!m_locked) begin
        if (oh) begin
          m_run  = mt ? m_run + 1 : 1;
          m_prev = w;
          m_have = 1;
          if (m_run == LOCK_CNT) begin m_locked = 1; m_miss = 0; end
        end else begin
          m_run = 0; m_have = 0;
        end
      end else if (mt) begin
        m_miss = 0; m_prev = w;
      end else begin
        m_err = 1; m_bad = w; m_miss++; m_prev = next_w(m_prev);
        if (m_miss == MISS_MAX) begin m_locked = 0; m_run = 0; m_have = 0; end
      end
    end
    if (clr) m_cnt = 0;
    if (m_err && m_cnt != 255) m_cnt++;
    exp_q.push_back(snapshot());
    @(posedge clk); #1;
    compare(tag);
  endtask

  initial begin
    rst = 1'b1; ring_in = '0; sample_en = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    do_reset("reset");

    // 1: acquire lock
    drive(4'b0001, 1, 0, "t1_s0");
    drive(4'b0010, 1, 0, "t1_s1");
    check("t1_not_yet_locked", 32'(locked), 32'd0);
    drive(4'b0100, 1, 0, "t1_s2");
    check("t1_locked", 32'(locked), 32'd1);

    // 2: wrap-around while locked
    drive(4'b1000, 1, 0, "t2_s3");
    drive(4'b0001, 1, 0, "t2_wrap");
    check("t2_wrap_index", 32'(index), 32'd0);
    drive(4'b0010, 1, 0, "t2_s1");

    // 3: single glitch, freewheel recovers
    drive(4'b0110, 1, 0, "t3_glitch");
    check("t3_err", 32'(err), 32'd1);
    check("t3_err_count", 32'(err_count), 32'd1);
    drive(4'b1000, 1, 0, "t3_recover");
    check("t3_still_locked", 32'(locked), 32'd1);
`ifdef RING_CAPTURE_EN
    check("t6_bad_word", 32'(bad_word), 32'h6);
`endif

    // clear alone, with sample_en low
    drive(4'b0000, 0, 1, "clr_idle");
    check("clr_idle_zero", 32'(err_count), 32'd0);
`ifdef RING_CAPTURE_EN
    check("t6_bad_word_kept", 32'(bad_word), 32'h6);
`endif

    // 4: two misses lose lock, then hold
    drive(4'b0000, 1, 0, "t4_miss0");
    drive(4'b0000, 1, 0, "t4_miss1");
    check("t4_err_count", 32'(err_count), 32'd2);
    check("t4_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) drive(4'b0001, 0, 0, $sformatf("t4_hold%0d", i));

    drive(4'b0001, 1, 0, "t4_relock0");
    drive(4'b0010, 1, 0, "t4_relock1");
    drive(4'b0100, 1, 0, "t4_relock2");
    ring_in = 4'b1000; sample_en = 1'b1; clr_err = 1'b1;
    do_reset("t4_midrun_reset");
    check("t4_rst_count", 32'(err_count), 32'd0);

    // 5: saturate the counter
    drive(4'b0010, 1, 0, "t5_lock0");
    drive(4'b0100, 1, 0, "t5_lock1");
    drive(4'b1000, 1, 0, "t5_lock2");
    for (int i = 0; i < 258; i++) begin
      drive(4'b0000, 1, 0, $sformatf("t5_bad%0d", i));
      drive(next_w(m_prev), 1, 0, $sformatf("t5_good%0d", i));
    end
    check("t5_saturated", 32'(err_count), 32'd255);
    drive(4'b0000, 1, 1, "t5_clr_with_err");
    check("t5_clr_with_err_one", 32'(err_count), 32'd1);
    drive(4'b0000, 0, 1, "t5_clr_alone");
    check("t5_clr_alone_zero", 32'(err_count), 32'd0);

    do_reset("final_reset");
`ifdef RING_CAPTURE_EN
    check("t6_bad_word_rst", 32'(bad_word), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ring_counter_checker.md
Name: ring_counter_checker

Overview:
- Receive-side companion to the N-bit one-hot ring counter.
- Samples a ring word and decodes it to a binary index.
- Checks each sample is one-hot and is exactly one rotation step from the previous sample.
- Acquires and loses lock through a two-state FSM and keeps a saturating error count.
- Sits beside any ring-counter-driven sequencer as a health monitor.

Parameters:
- N, 4, ring width in bits; must be >= 2.
- LOCK_CNT, 3, consecutive correct one-hot samples needed to declare lock; range 1..15.
- MISS_MAX, 2, consecutive mismatches while locked that force loss of lock; range 1..15.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ring_in  in  N  ring word under test.
- sample_en  in  1  qualifies ring_in this cycle.
- clr_err  in  1  synchronous clear of err_count.
- index  out  $clog2(N)  binary position of the set bit in the last valid one-hot sample.
- onehot_ok  out  1  last sample had exactly one bit set.
- locked  out  1  FSM is in LOCKED.
- err  out  1  one-cycle pulse on a locked-state mismatch.
- err_count  out  CNT_W  saturating count of err pulses.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: all outputs 0, FSM UNLOCKED, run_cnt 0, miss_cnt 0, prev 0, have_prev 0.
  - Reset asserted mid-operation wins over every other input and takes effect on the next edge.
- Rotation convention: next(w) = {w[N-2:0], w[N-1]}, so bit i moves to bit i+1 and bit N-1 wraps to bit 0.
  - Example, N=4: 1000 -> 0001.
- All outputs are registered; latency is 1 cycle from the sample_en edge.
- sample_en=0: all state and outputs hold; err=0.
- match = have_prev and (ring_in == next(prev)).
- onehot = exactly one bit of ring_in is set. All-zero and multi-hot are both non-one-hot.
- Every sampled cycle: onehot_ok <= onehot. If onehot, index <= position of the set bit; otherwise index holds.
- FSM state UNLOCKED:
  - err is never raised.
  - onehot and match: run_cnt++, prev <= ring_in.
  - onehot and not match: run_cnt <= 1, prev <= ring_in, have_prev <= 1.
  - not onehot: run_cnt <= 0, have_prev <= 0.
  - When run_cnt reaches LOCK_CNT, go to LOCKED: locked=1 on the same edge, miss_cnt <= 0.
  - LOCK_CNT=1 locks on the first one-hot sample.
- FSM state LOCKED:
  - match: miss_cnt <= 0, prev <= ring_in.
  - mismatch (including non-one-hot): err=1 for one cycle, err_count saturating-increments, miss_cnt++.
    - prev <= next(prev) (freewheel), so a single-sample glitch does not cause a second error.
  - When miss_cnt reaches MISS_MAX, go to UNLOCKED: locked=0, run_cnt <= 0, have_prev <= 0.
  - err still pulses for that final miss.
- err_count:
  - Saturates at 2^CNT_W-1, with no wrap.
  - clr_err alone clears it to 0.
  - clr_err together with an err event gives err_count = 1 (clear, then count the new event).
  - clr_err while sample_en=0 still clears.
- Wrap-around: N=4 sequence 1000 -> 0001 is a match; index goes 3 -> 0.

Optional Feature:
- Macro: RING_CAPTURE_EN.
- When defined:
  - Adds output bad_word, N bits, reset 0.
  - On every err pulse, bad_word <= the offending ring_in.
  - Otherwise bad_word holds. It is not cleared by clr_err, only by rst.
- When undefined: port and register are absent; all other behaviour is identical.

Test Plan:
Bench settings: N=4, LOCK_CNT=3, MISS_MAX=2, CNT_W=8.
1. rst, then sample 0001, 0010, 0100 -> index 0, 1, 2; locked=1 one cycle after the 0100 sample; err stays 0.
2. Locked at 0100, sample 1000, 0001, 0010 -> index 3, 0, 1 (wrap); err never asserted; locked stays 1.
3. Locked at 0010, sample 0110 then 1000 -> one err pulse and err_count=1, onehot_ok=0 then 1; the 1000 sample matches the freewheeled expectation; locked stays 1.
4. Locked, two consecutive bad samples 0000 -> err pulses twice, err_count=2, locked=0 after the second; then 0001 with sample_en=0 for 5 cycles -> all outputs hold. Assert rst mid-run -> every output 0 next cycle.
5. Force err_count to 255 via repeated lock/mismatch -> it stays 255. clr_err together with an error -> err_count=1. clr_err alone -> 0.
6. With RING_CAPTURE_EN: case 3 -> bad_word=0110; clr_err leaves bad_word=0110; rst -> 0000.
